icache_refill_ctrl: RTL and testbench

- Miss/refill sequencer for the L1 instruction cache in fetch stage 1.
- Latches a cache miss and issues one line request to lower memory over a valid/ready handshake.
- Assembles the multi-beat response into a full cache line and drives the cache write port for one cycle.
- Holds busy so fetch stays stalled until the refilled line is visible.

---
 rtl/fetch_refill_pkg.sv | 15 +
 rtl/icache_refill_buf.sv | 43 ++++
 rtl/icache_refill_ctrl.sv | 102 ++++++++++
 tb/tb_icache_refill_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_refill_pkg.sv
// fetch_refill_pkg: refill FSM states, line geometry constants and the line-address alignment helper
package fetch_refill_pkg;
    localparam int LINE_BITS = 256;
    localparam int BEAT_BITS = 64;
    localparam int BEATS     = LINE_BITS / BEAT_BITS;
    localparam int CNT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int OFF_BITS  = $clog2(LINE_BITS / 8);

    typedef enum logic [2:0] {IDLE, REQ, FILL, WRITE, ERR, SETTLE} refillState_t;

    // Clears the byte offset so the address points at the start of its cache line.
    function automatic logic [63:0] lineAlign(input logic [63:0] addr);
        return {addr[63:OFF_BITS], OFF_BITS'(0)};
    endfunction
endpackage

// File: rtl/icache_refill_buf.sv
// icache_refill_buf: assembles response beats into a cache line, tracks the beat index and a sticky error
//   clk, reset     clock, asynchronous active-low reset
//   clear          zero the beat counter and error latch
//   beatValid      accept beatData/beatErr into the current beat slot
//   line           assembled line, beat k at [k*BEAT_W +: BEAT_W]
//   lastBeat       the accepted beat is the final one of the line
//   errNext        error latch value including the beat being accepted now
module icache_refill_buf
    import fetch_refill_pkg::*;
#(
    parameter int LINE_W = LINE_BITS,
    parameter int BEAT_W = BEAT_BITS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              beatValid,
    input  logic [BEAT_W-1:0] beatData,
    input  logic              beatErr,
    output logic [LINE_W-1:0] line,
    output logic              lastBeat,
    output logic              errNext
);
    logic [CNT_W-1:0] count;
    logic             errLatch;

    assign lastBeat = beatValid && (count == CNT_W'(BEATS - 1));
    assign errNext  = errLatch || (beatValid && beatErr);

    // The counter returns to zero on the last beat instead of wrapping through increment.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count    <= '0;
            errLatch <= 1'b0;
            line     <= '0;
        end else begin
            count    <= (clear || lastBeat) ? '0 : beatValid ? count + 1'b1 : count;
            errLatch <= clear ? 1'b0 : errNext;
            if (beatValid)
                line[int'(count) * BEAT_W +: BEAT_W] <= beatData;
        end
    end
endmodule

// File: rtl/icache_refill_ctrl.sv
// icache_refill_ctrl: L1 I-cache miss/refill sequencer: one line request, beat assembly, single-cycle line write
//   clk, reset                       clock, asynchronous active-low reset
//   miss_i, missAddr_i, flush_i      miss from fetch stage 1 and fetch-control flush
//   memReqValid_o/Ready_i/Addr_o     line request handshake to lower memory
//   memRespValid_i/Data_i/Err_i      response beats (never back-pressured)
//   wrEnable_o, wrAddr_o, instBlock_o  cache line write port
//   busy_o                           fetch stall while a refill is in flight
//   errFlag_o                        one-cycle pulse when a refill is dropped due to a beat error
module icache_refill_ctrl
    import fetch_refill_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int LINE_W = LINE_BITS,
    parameter int BEAT_W = BEAT_BITS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              miss_i,
    input  logic [ADDR_W-1:0] missAddr_i,
    input  logic              flush_i,
    output logic              memReqValid_o,
    input  logic              memReqReady_i,
    output logic [ADDR_W-1:0] memReqAddr_o,
    input  logic              memRespValid_i,
    input  logic [BEAT_W-1:0] memRespData_i,
    input  logic              memRespErr_i,
    output logic              wrEnable_o,
    output logic [ADDR_W-1:0] wrAddr_o,
    output logic [LINE_W-1:0] instBlock_o,
    output logic              busy_o,
    output logic              errFlag_o
);
    refillState_t      state;
    logic [ADDR_W-1:0] lineAddr;
    logic              bufClear;
    logic              beatValid;
    logic              lastBeat;
    logic              errNext;

    assign memReqAddr_o = lineAddr;
    assign wrAddr_o     = lineAddr;
    // Counter restarts when the request is accepted; the error latch is dropped while reporting it.
    assign bufClear     = (state == REQ && memReqReady_i) || state == ERR;
    assign beatValid    = state == FILL && memRespValid_i;

    icache_refill_buf #(
        .LINE_W(LINE_W),
        .BEAT_W(BEAT_W)
    ) lineBuf (
        .clk      (clk),
        .reset    (reset),
        .clear    (bufClear),
        .beatValid(beatValid),
        .beatData (memRespData_i),
        .beatErr  (memRespErr_i),
        .line     (instBlock_o),
        .lastBeat (lastBeat),
        .errNext  (errNext)
    );

    // Flush only matters in IDLE (wrong-path miss); once requested, the line is fetched and written.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            lineAddr      <= '0;
            memReqValid_o <= 1'b0;
            busy_o        <= 1'b0;
            wrEnable_o    <= 1'b0;
            errFlag_o     <= 1'b0;
        end else begin
            wrEnable_o <= 1'b0;
            errFlag_o  <= 1'b0;
            case (state)
                IDLE: if (miss_i && !flush_i) begin
                    state         <= REQ;
                    lineAddr      <= ADDR_W'(lineAlign(64'(missAddr_i)));
                    memReqValid_o <= 1'b1;
                    busy_o        <= 1'b1;
                end
                REQ: if (memReqReady_i) begin
                    state         <= FILL;
                    memReqValid_o <= 1'b0;
                end
                FILL: if (lastBeat) begin
                    state      <= errNext ? ERR : WRITE;
                    wrEnable_o <= !errNext;
                    errFlag_o  <= errNext;
                end
                WRITE, ERR: state <= SETTLE;
                SETTLE: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
                default: begin
                    state         <= IDLE;
                    memReqValid_o <= 1'b0;
                    busy_o        <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_icache_refill_ctrl.sv
// tb_icache_refill_ctrl: randomized refill traffic checked by a queue scoreboard and a line-level reference model
module tb_icache_refill_ctrl;
    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         miss_i = 1'b0;
    logic [31:0]  missAddr_i = '0;
    logic         flush_i = 1'b0;
    logic         memReqValid_o;
    logic         memReqReady_i = 1'b0;
    logic [31:0]  memReqAddr_o;
    logic         memRespValid_i = 1'b0;
    logic [63:0]  memRespData_i = '0;
    logic         memRespErr_i = 1'b0;
    logic         wrEnable_o;
    logic [31:0]  wrAddr_o;
    logic [255:0] instBlock_o;
    logic         busy_o;
    logic         errFlag_o;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        bit           isErr;
        logic [31:0]  addr;
        logic [255:0] line;
    } outcome_t;

    outcome_t    expQ[$];
    logic [31:0] reqQ[$];
    outcome_t    popped;
    logic        prevValid = 1'b0;
    logic        prevReady = 1'b0;
    logic [31:0] prevAddr = '0;

    icache_refill_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .miss_i        (miss_i),
        .missAddr_i    (missAddr_i),
        .flush_i       (flush_i),
        .memReqValid_o (memReqValid_o),
        .memReqReady_i (memReqReady_i),
        .memReqAddr_o  (memReqAddr_o),
        .memRespValid_i(memRespValid_i),
        .memRespData_i (memRespData_i),
        .memRespErr_i  (memRespErr_i),
        .wrEnable_o    (wrEnable_o),
        .wrAddr_o      (wrAddr_o),
        .instBlock_o   (instBlock_o),
        .busy_o        (busy_o),
        .errFlag_o     (errFlag_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: DUT produced an output with nothing expected", name);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: samples on the falling edge, pops the scoreboard whenever the DUT presents a result.
    always @(negedge clk) begin
        if (reset) begin
            if (prevValid && !prevReady) begin
                check("req_hold_valid", memReqValid_o, 1);
                check("req_hold_addr", memReqAddr_o, prevAddr);
            end
            if (memReqValid_o && memReqReady_i) begin
                if (reqQ.size() == 0) fail("req_unexpected");
                else check("req_addr", memReqAddr_o, reqQ.pop_front());
            end
            if (wrEnable_o || errFlag_o) begin
                check("wr_err_exclusive", wrEnable_o && errFlag_o, 0);
                if (expQ.size() == 0) fail("outcome_unexpected");
                else begin
                    popped = expQ.pop_front();
                    check("outcome_is_err", errFlag_o, popped.isErr);
                    if (!popped.isErr) begin
                        check("wr_addr", wrAddr_o, popped.addr);
                        check("wr_line", instBlock_o, popped.line);
                    end
                end
            end
        end
        prevValid = reset && memReqValid_o;
        prevReady = memReqReady_i;
        prevAddr  = memReqAddr_o;
    end

    // One complete refill: the model is the aligned line address plus the beats laid out by offset.
    task automatic refill(input logic [31:0] addr, input int readyDelay, input int maxGap,
                          input int errMask, input bit flushMid, input bit holdMiss);
        logic [63:0] d[4];
        outcome_t    e;
        e.addr  = addr - (addr % 32);
        e.isErr = errMask != 0;
        e.line  = '0;
        for (int k = 0; k < 4; k++) begin
            d[k] = {$urandom, $urandom};
            e.line[k*64 +: 64] = d[k];
        end
        reqQ.push_back(e.addr);
        expQ.push_back(e);
        miss_i = 1'b1;
        missAddr_i = addr;
        flush_i = 1'b0;
        step();
        miss_i = holdMiss;
        check("req_valid_t1", memReqValid_o, 1);
        check("busy_t1", busy_o, 1);
        memReqReady_i = 1'b0;
        for (int i = 0; i <= readyDelay; i++) begin
            memReqReady_i = i == readyDelay;
            memRespValid_i = $urandom_range(0, 1);
            memRespErr_i = $urandom_range(0, 1);
            memRespData_i = {$urandom, $urandom};
            step();
        end
        memReqReady_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            repeat ($urandom_range(0, maxGap)) begin
                memRespValid_i = 1'b0;
                memRespErr_i = $urandom_range(0, 1);
                memRespData_i = {$urandom, $urandom};
                step();
            end
            memRespValid_i = 1'b1;
            memRespData_i = d[k];
            memRespErr_i = errMask[k];
            if (flushMid && k == 1) begin
                flush_i = 1'b1;
                miss_i = 1'b1;
                missAddr_i = addr + 32;
            end
            step();
            flush_i = 1'b0;
            miss_i = holdMiss;
            missAddr_i = addr;
        end
        memRespValid_i = 1'b0;
        memRespErr_i = 1'b0;
        check("end_wr", wrEnable_o, !e.isErr);
        check("end_err", errFlag_o, e.isErr);
        check("end_busy", busy_o, 1);
        step();
        check("settle_busy", busy_o, 1);
        check("settle_no_wr", wrEnable_o, 0);
        check("settle_no_err", errFlag_o, 0);
        step();
        check("idle_busy", busy_o, 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", memReqValid_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_wr", wrEnable_o, 0);
        check("rst_err", errFlag_o, 0);
        check("rst_line", instBlock_o, 0);
        reset = 1'b1;
        step();

        refill(32'h0000_1234, 0, 0, 0, 1'b0, 1'b0);
        refill(32'h0000_8a7f, 5, 2, 0, 1'b0, 1'b0);
        refill(32'h0040_0010, 1, 1, 4'b0010, 1'b0, 1'b0);

        miss_i = 1'b1;
        flush_i = 1'b1;
        missAddr_i = 32'h0000_5000;
        step();
        miss_i = 1'b0;
        flush_i = 1'b0;
        check("flush_drop_valid", memReqValid_o, 0);
        check("flush_drop_busy", busy_o, 0);
        repeat (3) step();

        refill(32'h1234_5678, 2, 1, 0, 1'b1, 1'b0);
        refill(32'h0000_3c44, 0, 0, 0, 1'b0, 1'b1);
        refill(32'h0000_7000, 0, 0, 0, 1'b0, 1'b0);

        // Abort mid-fill: two beats in, then reset; later beats must not produce a write.
        reqQ.push_back(32'h0009_9980);
        miss_i = 1'b1;
        missAddr_i = 32'h0009_999c;
        step();
        miss_i = 1'b0;
        memReqReady_i = 1'b1;
        step();
        memReqReady_i = 1'b0;
        for (int k = 0; k < 2; k++) begin
            memRespValid_i = 1'b1;
            memRespData_i = {$urandom, $urandom};
            step();
        end
        memRespValid_i = 1'b0;
        reset = 1'b0;
        #1;
        check("abort_valid", memReqValid_o, 0);
        check("abort_busy", busy_o, 0);
        check("abort_line", instBlock_o, 0);
        check("abort_addr", memReqAddr_o, 0);
        step();
        reset = 1'b1;
        for (int k = 0; k < 2; k++) begin
            memRespValid_i = 1'b1;
            memRespData_i = {$urandom, $urandom};
            step();
        end
        memRespValid_i = 1'b0;
        repeat (3) step();
        check("abort_idle_busy", busy_o, 0);

        for (int i = 0; i < 25; i++)
            refill($urandom, $urandom_range(0, 6), $urandom_range(0, 3),
                   ($urandom_range(0, 3) == 0) ? $urandom_range(1, 15) : 0,
                   $urandom_range(0, 3) == 0, i < 24 && $urandom_range(0, 4) == 0);

        miss_i = 1'b0;
        repeat (5) step();
        check("req_queue_drained", reqQ.size(), 0);
        check("outcome_queue_drained", expQ.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
